// File: rtl/if_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : if_ctl_if
// Description : Bundle of the fetch controller's external signals.
//               The master modport is the fetch controller's view and the
//               slave modport is the surrounding pipeline and I-cache view.
//   redirect     backend -> fetch   redirect request (branch/trap)
//   redirect_pc  backend -> fetch   new fetch target (low two bits ignored)
//   be_stall     backend -> fetch   hold the current predecode input
//   ic_req       fetch -> I-cache   request valid
//   ic_addr      fetch -> I-cache   word address of the request
//   ic_ack       I-cache -> fetch   response valid for the outstanding request
//   ic_data      I-cache -> fetch   instruction word, valid with ic_ack
//   pd_pc        fetch -> predecode PC of the presented instruction
//   pd_ir        fetch -> predecode presented instruction
//   pd_stall     fetch -> predecode stall
// Revision    : 1.0 - initial release
// ============================================================================
interface if_ctl_if;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        be_stall;
  logic        ic_req;
  logic [63:0] ic_addr;
  logic        ic_ack;
  logic [31:0] ic_data;
  logic [63:0] pd_pc;
  logic [31:0] pd_ir;
  logic        pd_stall;

  modport master (
    input  redirect, redirect_pc, be_stall, ic_ack, ic_data,
    output ic_req, ic_addr, pd_pc, pd_ir, pd_stall
  );

  modport slave (
    output redirect, redirect_pc, be_stall, ic_ack, ic_data,
    input  ic_req, ic_addr, pd_pc, pd_ir, pd_stall
  );
endinterface
`default_nettype wire

// File: rtl/if_ctl.sv
`default_nettype none
// ============================================================================
// Module      : if_ctl
// Description : Fetch-stage controller. Generates the sequential fetch PC,
//               issues single-outstanding word requests to the I-cache,
//               buffers returned words in a QDEPTH-entry queue and presents
//               the queue head (PC + instruction) to predecode. Redirects
//               flush the queue and discard any stale in-flight response.
//               All state changes on the falling edge of clk.
// Ports       : clk  - hart clock (falling edge active)
//               rst  - synchronous active-high reset
//               bus  - if_ctl_if.master: redirect/be_stall from the backend,
//                      ic_req/ic_addr/ic_ack/ic_data to the I-cache,
//                      pd_pc/pd_ir/pd_stall to predecode
// Revision    : 1.0 - initial release
// ============================================================================
module if_ctl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  wire logic clk,
  input  wire logic rst,
  if_ctl_if.master  bus
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [63:0]   pc_mem_q [QDEPTH];
  logic [31:0]   ir_mem_q [QDEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] count_after_pop;

  // Word alignment drops the two low redirect bits.
  logic unused_rpc_lsbs;
  assign unused_rpc_lsbs = ^bus.redirect_pc[1:0];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    pop             = (count_q != '0) && !bus.be_stall && !bus.redirect;
    push            = (state_q == REQ) && bus.ic_ack && !bus.redirect;
    count_after_pop = count_q - CW'(pop);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (bus.redirect) begin
      // Flush: pointers return to zero along with the count.
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = {bus.redirect_pc[63:2], 2'b00};
      unique case (state_q)
        IDLE:    state_d = REQ;
        // Without an ack the old request is still out at the cache and its
        // response must be swallowed before a new request may be issued.
        REQ:     state_d = bus.ic_ack ? REQ : DRAIN;
        // If the awaited stale response lands on this very edge there is
        // nothing left to drain; waiting here would never see another ack.
        DRAIN:   state_d = bus.ic_ack ? REQ : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      count_d = count_after_pop + CW'(push);
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (push) begin
        tail_d     = tail_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      unique case (state_q)
        IDLE: begin
          // An ack seen while idle is not ours and is ignored.
          if (count_after_pop < DEPTH_C) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (bus.ic_ack) begin
            state_d = (count_d < DEPTH_C) ? REQ : IDLE;
          end
        end
        DRAIN: begin
          if (bus.ic_ack) begin
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      // A push into a full queue without a matching pop loses an instruction.
      assert (!(push && !pop && (count_q == DEPTH_C)));
    end
  end

  // Queue storage needs no reset: entries are only read while count_q > 0.
  always_ff @(negedge clk) begin
    if (push) begin
      pc_mem_q[tail_q] <= fetch_pc_q;
      ir_mem_q[tail_q] <= bus.ic_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.ic_req  = (state_q == REQ);
    bus.ic_addr = fetch_pc_q;
    if (count_q != '0) begin
      bus.pd_pc    = pc_mem_q[head_q];
      bus.pd_ir    = ir_mem_q[head_q];
      bus.pd_stall = bus.be_stall;
    end else begin
      bus.pd_pc    = 64'h0;
      bus.pd_ir    = NOP;
      bus.pd_stall = 1'b1;
    end
  end

endmodule
`default_nettype wire
